node_elastic_buf: RTL and testbench

- Parameterised elastic buffer that sits directly downstream of a valid/ready pass-through node and consumes its data/valid output.
- It cuts every combinational path between its upstream and downstream interfaces: valid, data and ready are all driven from flops.
- It sustains one transfer per cycle when DEPTH >= 2.
- It reports occupancy and a saturating downstream-stall counter for performance debug.

---
 rtl/node_elastic_buf_pkg.sv | 16 +
 rtl/node_elastic_buf_if.sv | 22 ++
 rtl/node_elastic_buf_mem.sv | 27 ++
 rtl/node_elastic_buf.sv | 87 ++++++++
 tb/tb_node_elastic_buf.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/node_elastic_buf_pkg.sv
// Shared definitions for the elastic buffer: pointer-width helper, default
// occupancy type and the all-ones pattern used to saturate the stall counter.
package node_elastic_buf_pkg;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEFAULT_DEPTH = 4;

    typedef logic [ptr_w(DEFAULT_DEPTH):0] count_t;

    // Sliced down to CNT_W by users; supports counters up to 64 bits.
    localparam logic [63:0] STALL_SAT = '1;

endpackage

// File: rtl/node_elastic_buf_if.sv
// Upstream and downstream valid/ready/data signals of the elastic buffer.
// slave is the buffer side, master is the environment side.
interface node_elastic_buf_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             valid_up_in;
    logic             ready_up_out;
    logic [WIDTH-1:0] data_out;
    logic             valid_down_out;
    logic             ready_down_in;

    modport master (
        output data_in, valid_up_in, ready_down_in,
        input  ready_up_out, data_out, valid_down_out
    );

    modport slave (
        input  data_in, valid_up_in, ready_down_in,
        output ready_up_out, data_out, valid_down_out
    );
endinterface

// File: rtl/node_elastic_buf_mem.sv
// DEPTH x WIDTH flop storage with reset-to-zero, one synchronous write port
// and one asynchronous read port.
module node_elastic_buf_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/node_elastic_buf.sv
// Fully registered elastic buffer: ready, valid and data all come from flops.
// Tracks occupancy and a saturating count of downstream stall cycles.
module node_elastic_buf
    import node_elastic_buf_pkg::*;
#(
    parameter int   WIDTH = 32,
    parameter int   DEPTH = 4,
    parameter int   CNT_W = 16,
    localparam int  PTR_W = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    node_elastic_buf_if.slave bus,
    output logic [PTR_W:0]    count,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [PTR_W:0]   FULL      = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_MAX = STALL_SAT[CNT_W-1:0];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             up_fire, down_fire, mem_we;

    assign up_fire   = bus.valid_up_in & ready_q;
    assign down_fire = valid_q & bus.ready_down_in;

    always_comb begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        // A push accepted in the flush cycle is acknowledged but never stored.
        mem_we   = up_fire & ~flush;
        if (!flush) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(up_fire);
            rd_ptr_d = rd_ptr_q + PTR_W'(down_fire);
            count_d  = count_q + (PTR_W+1)'(up_fire) - (PTR_W+1)'(down_fire);
        end
        valid_d = (count_d != '0);
        ready_d = (count_d < FULL);
        stall_d = stall_q;
        if (valid_q && !bus.ready_down_in && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            stall_q  <= stall_d;
        end
    end

    node_elastic_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (bus.data_out)
    );

    assign bus.ready_up_out   = ready_q;
    assign bus.valid_down_out = valid_q;
    assign count              = count_q;
    assign stall_cnt          = stall_q;
endmodule

// File: tb/tb_node_elastic_buf.sv
// Directed plus randomized bench for node_elastic_buf against a queue-based
// reference model of the buffer's observable behaviour.
module tb_node_elastic_buf;
    import node_elastic_buf_pkg::*;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 4;
    localparam int STALL_LIM = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    count_t           count;
    logic [CNT_W-1:0] stall_cnt;

    node_elastic_buf_if #(.WIDTH(WIDTH)) bus ();

    node_elastic_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] out_log[$];
    bit               m_valid;
    bit               m_ready;
    int               m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_ready = 1'b0;
        m_stall = 0;
    endtask

    // Advance the reference by one clock edge using the inputs held across it.
    task automatic model_edge();
        bit up, dn;
        up = bus.valid_up_in && m_ready;
        dn = m_valid && bus.ready_down_in;
        if (m_valid && !bus.ready_down_in && m_stall < STALL_LIM) m_stall++;
        if (dn) out_log.push_back(mq.pop_front());
        if (flush) mq.delete();
        else if (up) mq.push_back(bus.data_in);
        m_valid = (mq.size() != 0);
        m_ready = (mq.size() < DEPTH);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ready"}, bus.ready_up_out, m_ready);
        chk({tag, "_valid"}, bus.valid_down_out, m_valid);
        chk({tag, "_count"}, count, mq.size());
        chk({tag, "_stall"}, stall_cnt, m_stall);
        chk({tag, "_cnt_le_depth"}, (count <= DEPTH), 1);
        if (m_valid) chk({tag, "_data"}, bus.data_out, mq[0]);
    endtask

    task automatic edge_step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, bus.ready_up_out, 0);
        chk({tag, "_valid"}, bus.valid_down_out, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_data"}, bus.data_out, 0);
        chk({tag, "_stall"}, stall_cnt, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] in_words[$];
        logic [WIDTH-1:0] fill_exp[4];
        int               base, bad;

        bus.data_in       = '0;
        bus.valid_up_in   = 1'b0;
        bus.ready_down_in = 1'b0;
        model_reset();

        // Reset and idle
        #2;
        check_reset_values("rst");
        #10 rst_n = 1'b1;
        edge_step("rst_release");
        chk("rst_first_ready", bus.ready_up_out, 1);

        // Single word, one-cycle latency
        bus.valid_up_in   = 1'b1;
        bus.data_in       = 32'hA5A5_0001;
        bus.ready_down_in = 1'b1;
        edge_step("single_push");
        chk("single_valid", bus.valid_down_out, 1);
        chk("single_data", bus.data_out, 32'hA5A5_0001);
        bus.valid_up_in = 1'b0;
        edge_step("single_pop");
        chk("single_count0", count, 0);

        // Fill to full under downstream stall
        bus.ready_down_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.valid_up_in = 1'b1;
            bus.data_in     = 32'h10 + i;
            edge_step("fill");
        end
        bus.valid_up_in = 1'b0;
        chk("fill_count4", count, 4);
        chk("fill_ready0", bus.ready_up_out, 0);
        chk("fill_stall3", stall_cnt, 3);
        chk("fill_head", bus.data_out, 32'h10);
        base = out_log.size();
        bus.ready_down_in = 1'b1;
        for (int i = 0; i < 4; i++) edge_step("drain");
        fill_exp = '{32'h10, 32'h11, 32'h12, 32'h13};
        chk("drain_n", out_log.size() - base, 4);
        for (int i = 0; i < 4; i++) chk("drain_order", out_log[base + i], fill_exp[i]);

        // Streaming, both sides always ready
        base = out_log.size();
        in_words.delete();
        bus.ready_down_in = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.valid_up_in = 1'b1;
            bus.data_in     = $urandom;
            in_words.push_back(bus.data_in);
            edge_step("stream");
            chk("stream_cnt_le2", (count <= 2), 1);
            chk("stream_valid", bus.valid_down_out, 1);
        end
        bus.valid_up_in = 1'b0;
        edge_step("stream_tail");
        chk("stream_n", out_log.size() - base, 1000);
        bad = 0;
        for (int i = 0; i < 1000; i++) if (out_log[base + i] !== in_words[i]) bad++;
        chk("stream_order", bad, 0);

        // Flush with three entries and a concurrent push
        bus.ready_down_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.valid_up_in = 1'b1;
            bus.data_in     = 32'h300 + i;
            edge_step("preflush");
        end
        chk("preflush_count3", count, 3);
        flush           = 1'b1;
        bus.valid_up_in = 1'b1;
        bus.data_in     = 32'h0000_DEAD;
        edge_step("flush");
        flush           = 1'b0;
        bus.valid_up_in = 1'b0;
        chk("flush_count0", count, 0);
        chk("flush_valid0", bus.valid_down_out, 0);
        chk("flush_ready1", bus.ready_up_out, 1);
        bus.ready_down_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_step("postflush");
            chk("flush_no_dead", (bus.data_out === 32'h0000_DEAD), 0);
        end

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            bus.valid_up_in   = ($urandom_range(3) != 0);
            bus.ready_down_in = ($urandom_range(2) != 0);
            bus.data_in       = $urandom;
            flush             = ($urandom_range(49) == 0);
            edge_step("rand");
        end
        flush = 1'b0;

        // Asynchronous reset mid-stream
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        chk("midrst_hold_ready", bus.ready_up_out, 0);
        #2 rst_n = 1'b1;
        bus.valid_up_in = 1'b0;
        edge_step("midrst_release");

        // Stall counter saturation
        bus.valid_up_in   = 1'b1;
        bus.data_in       = 32'h5A5A_0042;
        bus.ready_down_in = 1'b0;
        edge_step("sat_push");
        bus.valid_up_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            edge_step("sat");
            chk("sat_stall", stall_cnt, (k < 15) ? k : 15);
            chk("sat_data_stable", bus.data_out, 32'h5A5A_0042);
        end
        chk("sat_final", stall_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
